// File: rtl/busca_instrucao_fila_pkg.sv
// Shared definitions for the instruction-fetch slice: reset defaults, PC step,
// queue-entry field layout and a constant log2 helper.
package busca_defs;

    localparam logic [31:0] PC_RESET_PADRAO   = 32'h0000_0000;
    localparam int          INCREMENTO_PADRAO = 4;

    // Queue entry is {instrucao, pc}; field k occupies bits [k*LARGURA +: LARGURA].
    localparam int CAMPO_PC        = 0;
    localparam int CAMPO_INSTRUCAO = 1;

    function automatic int clog2(input int valor);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < valor) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fila_instrucao.sv
// Synchronous FIFO with flush. When empty, dado_out keeps showing the last head
// that was visible, so downstream sees stable values while nothing is queued.
module fila_instrucao
    import busca_defs::*;
#(
    parameter int LARGURA_ENTRADA = 64,
    parameter int PROF            = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       limpar,
    input  logic                       escreve,
    input  logic                       le,
    input  logic [LARGURA_ENTRADA-1:0] dado_in,
    output logic [LARGURA_ENTRADA-1:0] dado_out,
    output logic                       vazia,
    output logic                       cheia,
    output logic [clog2(PROF):0]       contagem
);

    localparam int AW = clog2(PROF);

    logic [LARGURA_ENTRADA-1:0] mem [PROF];
    logic [LARGURA_ENTRADA-1:0] ultimo;
    logic [AW-1:0]              ptrLeitura;
    logic [AW-1:0]              ptrEscrita;
    logic                       fazLeitura;
    logic                       fazEscrita;

    assign vazia      = (contagem == '0);
    assign cheia      = (contagem == (AW+1)'(PROF));
    assign fazLeitura = le && !vazia;
    assign fazEscrita = escreve && (!cheia || fazLeitura);
    assign dado_out   = vazia ? ultimo : mem[ptrLeitura];

    always_ff @(posedge clock) begin
        if (fazEscrita && !limpar) mem[ptrEscrita] <= dado_in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptrLeitura <= '0;
            ptrEscrita <= '0;
            contagem   <= '0;
            ultimo     <= '0;
        end else begin
            if (!vazia) ultimo <= mem[ptrLeitura];
            if (limpar) begin
                ptrLeitura <= '0;
                ptrEscrita <= '0;
                contagem   <= '0;
            end else begin
                // PROF is a power of two, so pointers wrap on their own width.
                if (fazEscrita) ptrEscrita <= ptrEscrita + AW'(1);
                if (fazLeitura) ptrLeitura <= ptrLeitura + AW'(1);
                contagem <= contagem + (AW+1)'(fazEscrita) - (AW+1)'(fazLeitura);
            end
        end
    end

endmodule

// File: rtl/busca_instrucao_fila.sv
// Instruction-fetch stage: PC register, credit-limited prefetch, PC-tag FIFO and
// registered in-order instruction queue, with redirect flush of queued and in-flight fetches.
module busca_instrucao_fila
    import busca_defs::*;
#(
    parameter int                 LARGURA    = 32,
    parameter int                 PROF_FILA  = 4,
    parameter logic [LARGURA-1:0] PC_RESET   = LARGURA'(PC_RESET_PADRAO),
    parameter int                 INCREMENTO = INCREMENTO_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset_n,
    output logic                      mem_req,
    output logic [LARGURA-1:0]        mem_endereco,
    input  logic                      mem_pronto,
    input  logic                      mem_valido,
    input  logic [LARGURA-1:0]        mem_dados,
    input  logic                      desvio,
    input  logic [LARGURA-1:0]        desvio_alvo,
    input  logic                      id_pronto,
    output logic                      if_valido,
    output logic [LARGURA-1:0]        if_instrucao,
    output logic [LARGURA-1:0]        if_pc,
    output logic [LARGURA-1:0]        if_pc_mais4,
    output logic [clog2(PROF_FILA):0] ocupacao
);

    localparam int CW = clog2(PROF_FILA) + 1;

    logic [LARGURA-1:0]   pc;
    logic [CW-1:0]        pendentes;
    logic [CW-1:0]        descarte;
    logic [CW-1:0]        contagemFila;
    logic [CW-1:0]        contagemTag;
    logic                 aceito;
    logic                 guarda;
    logic                 consome;
    logic                 filaVazia;
    logic                 filaCheia;
    logic                 tagVazia;
    logic                 tagCheia;
    logic                 jaValido;
    logic [LARGURA-1:0]   tagPc;
    logic [2*LARGURA-1:0] entrada;
    logic [2*LARGURA-1:0] saida;

    // Credit counts both queued entries and every outstanding fetch, including ones to be dropped.
    assign ocupacao     = pendentes + contagemFila;
    assign mem_req      = reset_n && !desvio && (ocupacao < CW'(PROF_FILA));
    assign mem_endereco = pc;
    assign aceito       = mem_req && mem_pronto;
    assign guarda       = mem_valido && (descarte == '0) && !desvio;
    assign consome      = !filaVazia && id_pronto && !desvio;

    assign entrada[CAMPO_INSTRUCAO*LARGURA +: LARGURA] = mem_dados;
    assign entrada[CAMPO_PC*LARGURA +: LARGURA]        = tagPc;

    assign if_valido    = !filaVazia;
    assign if_instrucao = saida[CAMPO_INSTRUCAO*LARGURA +: LARGURA];
    assign if_pc        = saida[CAMPO_PC*LARGURA +: LARGURA];
    assign if_pc_mais4  = (jaValido || !filaVazia) ? if_pc + LARGURA'(INCREMENTO) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= PC_RESET;
            pendentes <= '0;
            descarte  <= '0;
            jaValido  <= 1'b0;
        end else begin
            if (desvio) begin
                // A response landing in the redirect cycle is dropped here, not counted as a discard.
                pc        <= {desvio_alvo[LARGURA-1:2], 2'b00};
                pendentes <= pendentes - CW'(mem_valido);
                descarte  <= pendentes - CW'(mem_valido);
            end else begin
                if (aceito) pc <= pc + LARGURA'(INCREMENTO);
                pendentes <= pendentes + CW'(aceito) - CW'(mem_valido);
                if (mem_valido && (descarte != '0)) descarte <= descarte - CW'(1);
            end
            if (!filaVazia) jaValido <= 1'b1;
        end
    end

    // Tags of fetches whose data will be kept; stale tags vanish with the redirect flush.
    fila_instrucao #(
        .LARGURA_ENTRADA(LARGURA),
        .PROF           (PROF_FILA)
    ) u_fila_tag (
        .clock   (clock),
        .reset_n (reset_n),
        .limpar  (desvio),
        .escreve (aceito),
        .le      (guarda),
        .dado_in (pc),
        .dado_out(tagPc),
        .vazia   (tagVazia),
        .cheia   (tagCheia),
        .contagem(contagemTag)
    );

    fila_instrucao #(
        .LARGURA_ENTRADA(2*LARGURA),
        .PROF           (PROF_FILA)
    ) u_fila_instr (
        .clock   (clock),
        .reset_n (reset_n),
        .limpar  (desvio),
        .escreve (guarda),
        .le      (consome),
        .dado_in (entrada),
        .dado_out(saida),
        .vazia   (filaVazia),
        .cheia   (filaCheia),
        .contagem(contagemFila)
    );

    a_pendentes_limite: assert property (@(posedge clock) disable iff (!reset_n)
        pendentes <= CW'(PROF_FILA));
    a_resposta_sem_pedido: assert property (@(posedge clock) disable iff (!reset_n)
        !(mem_valido && (pendentes == '0)));
    a_tag_sem_estouro: assert property (@(posedge clock) disable iff (!reset_n)
        !(aceito && tagCheia) && (contagemTag <= pendentes));
    a_fila_coerente: assert property (@(posedge clock) disable iff (!reset_n)
        !(guarda && (tagVazia || (filaCheia && !consome))));

endmodule

// File: tb/tb_busca_instrucao_fila.sv
// Bench for busca_instrucao_fila: queue-based reference model checked every cycle,
// directed fetch/stall/redirect/reset scenarios, randomized traffic and a PC-wrap instance.
module tb_busca_instrucao_fila;

    localparam int W    = 32;
    localparam int PROF = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_req;
    logic [W-1:0]  mem_endereco;
    logic          mem_pronto;
    logic          mem_valido;
    logic [W-1:0]  mem_dados;
    logic          desvio;
    logic [W-1:0]  desvio_alvo;
    logic          id_pronto;
    logic          if_valido;
    logic [W-1:0]  if_instrucao;
    logic [W-1:0]  if_pc;
    logic [W-1:0]  if_pc_mais4;
    logic [2:0]    ocupacao;

    logic          w_mem_req;
    logic [W-1:0]  w_mem_endereco;
    logic          w_mem_pronto;
    logic          w_mem_valido;
    logic [W-1:0]  w_mem_dados;
    logic          w_desvio;
    logic [W-1:0]  w_desvio_alvo;
    logic          w_id_pronto;
    logic          w_if_valido;
    logic [W-1:0]  w_if_instrucao;
    logic [W-1:0]  w_if_pc;
    logic [W-1:0]  w_if_pc_mais4;
    logic [2:0]    w_ocupacao;

    always #5 clock = ~clock;

    busca_instrucao_fila #(.LARGURA(W), .PROF_FILA(PROF), .PC_RESET(32'h0), .INCREMENTO(4)) u_dut (
        .clock(clock), .reset_n(reset_n), .mem_req(mem_req), .mem_endereco(mem_endereco),
        .mem_pronto(mem_pronto), .mem_valido(mem_valido), .mem_dados(mem_dados),
        .desvio(desvio), .desvio_alvo(desvio_alvo), .id_pronto(id_pronto),
        .if_valido(if_valido), .if_instrucao(if_instrucao), .if_pc(if_pc),
        .if_pc_mais4(if_pc_mais4), .ocupacao(ocupacao)
    );

    busca_instrucao_fila #(.LARGURA(W), .PROF_FILA(PROF), .PC_RESET(32'hFFFF_FFF8), .INCREMENTO(4)) u_wrap (
        .clock(clock), .reset_n(reset_n), .mem_req(w_mem_req), .mem_endereco(w_mem_endereco),
        .mem_pronto(w_mem_pronto), .mem_valido(w_mem_valido), .mem_dados(w_mem_dados),
        .desvio(w_desvio), .desvio_alvo(w_desvio_alvo), .id_pronto(w_id_pronto),
        .if_valido(w_if_valido), .if_instrucao(w_if_instrucao), .if_pc(w_if_pc),
        .if_pc_mais4(w_if_pc_mais4), .ocupacao(w_ocupacao)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Stimulus knobs (percent probabilities and latency range)
    int pPronto, pId, pDesvio, latMin, latMax;

    // Memory environment: answers whatever the DUT actually got accepted, in order
    logic [W-1:0] envAddr[$];
    int           envDue[$];
    int           lastDue;
    int           envAccepts;

    // Reference model: expected PC, outstanding fetches (with stale mark) and queued entries
    logic [W-1:0] mPc;
    logic [W-1:0] mReqAddr[$];
    bit           mReqStale[$];
    logic [W-1:0] mQPc[$];
    logic [W-1:0] mQInstr[$];
    logic [W-1:0] mLastPc, mLastInstr;
    bit           mShown;

    // Wrap instance: 1-cycle memory, records the first fetches and outputs
    bit           wRecord;
    bit           wAccPrev;
    logic [W-1:0] wAddrPrev;
    logic [W-1:0] wAcc[$];
    logic [W-1:0] wIfPc[$];
    logic [W-1:0] wIfInstr[$];
    logic [W-1:0] wIfPc4[$];

    function automatic logic [W-1:0] dataOf(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic setPhase(input int pr, input int pi, input int pd, input int lmin, input int lmax);
        pPronto = pr; pId = pi; pDesvio = pd; latMin = lmin; latMax = lmax;
    endtask

    task automatic clearAll();
        envAddr.delete(); envDue.delete(); lastDue = -100; envAccepts = 0; cyc = 0;
        mPc = 32'h0; mReqAddr.delete(); mReqStale.delete(); mQPc.delete(); mQInstr.delete();
        mLastPc = '0; mLastInstr = '0; mShown = 1'b0;
        wAccPrev = 1'b0; wAddrPrev = '0;
    endtask

    task automatic checkOutputs();
        logic [W-1:0] ePc, eIn;
        bit eVal;
        int occ;
        eVal = mQPc.size() != 0;
        ePc  = eVal ? mQPc[0] : mLastPc;
        eIn  = eVal ? mQInstr[0] : mLastInstr;
        occ  = mReqAddr.size() + mQPc.size();
        check("mem_req", 32'(mem_req), 32'(!desvio && (occ < PROF)));
        check("mem_endereco", mem_endereco, mPc);
        check("if_valido", 32'(if_valido), 32'(eVal));
        check("if_pc", if_pc, ePc);
        check("if_instrucao", if_instrucao, eIn);
        check("if_pc_mais4", if_pc_mais4, (eVal || mShown) ? ePc + 32'd4 : 32'd0);
        check("ocupacao", 32'(ocupacao), 32'(occ));
    endtask

    task automatic modelAdvance();
        bit expReq, keep, nonEmpty;
        logic [W-1:0] a;
        expReq = !desvio && ((mReqAddr.size() + mQPc.size()) < PROF);
        keep = 1'b0;
        a = '0;
        if (mem_valido) begin
            check("resposta_com_pedido", 32'(mReqAddr.size() != 0), 32'd1);
            if (mReqAddr.size() != 0) begin
                a = mReqAddr.pop_front();
                keep = !mReqStale.pop_front() && !desvio;
            end
        end
        nonEmpty = mQPc.size() != 0;
        if (nonEmpty) begin
            mLastPc = mQPc[0]; mLastInstr = mQInstr[0]; mShown = 1'b1;
        end
        if (desvio) begin
            mQPc.delete(); mQInstr.delete();
            foreach (mReqStale[i]) mReqStale[i] = 1'b1;
            mPc = {desvio_alvo[W-1:2], 2'b00};
        end else begin
            if (nonEmpty && id_pronto) begin
                void'(mQPc.pop_front()); void'(mQInstr.pop_front());
            end
            if (keep) begin
                mQPc.push_back(a); mQInstr.push_back(dataOf(a));
            end
            if (expReq && mem_pronto) begin
                mReqAddr.push_back(mPc); mReqStale.push_back(1'b0); mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic envAdvance();
        int due;
        if (mem_valido) begin
            void'(envAddr.pop_front()); void'(envDue.pop_front());
        end
        if (mem_req && mem_pronto) begin
            due = cyc + $urandom_range(latMax, latMin);
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            envAddr.push_back(mem_endereco); envDue.push_back(due);
            envAccepts++;
        end
        if (wRecord) begin
            if (w_mem_req && w_mem_pronto) wAcc.push_back(w_mem_endereco);
            if (w_if_valido) begin
                wIfPc.push_back(w_if_pc); wIfInstr.push_back(w_if_instrucao); wIfPc4.push_back(w_if_pc_mais4);
            end
        end
        wAccPrev  = w_mem_req && w_mem_pronto;
        wAddrPrev = w_mem_endereco;
    endtask

    // One clock cycle, entered right after a falling edge.
    task automatic step(input bit forceDesvio, input logic [W-1:0] alvo);
        mem_pronto  = ($urandom_range(99) < pPronto);
        id_pronto   = ($urandom_range(99) < pId);
        desvio      = forceDesvio || ($urandom_range(99) < pDesvio);
        desvio_alvo = forceDesvio ? alvo : $urandom;
        mem_valido  = (envDue.size() != 0) && (envDue[0] <= cyc);
        mem_dados   = mem_valido ? dataOf(envAddr[0]) : $urandom;
        w_mem_valido = wAccPrev;
        w_mem_dados  = dataOf(wAddrPrev);
        #1;
        checkOutputs();
        modelAdvance();
        envAdvance();
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic doReset(input int atraso);
        #(atraso);
        mem_valido = 1'b0; desvio = 1'b0; mem_pronto = 1'b0; id_pronto = 1'b0; w_mem_valido = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_endereco", mem_endereco, 32'h0);
        check("rst_if_valido", 32'(if_valido), 32'd0);
        check("rst_if_instrucao", if_instrucao, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_pc_mais4", if_pc_mais4, 32'h0);
        check("rst_ocupacao", 32'(ocupacao), 32'd0);
        clearAll();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic waitValid(input string name, input logic [W-1:0] pcEsperado);
        int n;
        n = 0;
        while (!if_valido && n < 30) begin
            step(1'b0, 32'h0);
            n++;
        end
        check({name, "_valido"}, 32'(if_valido), 32'd1);
        check({name, "_pc"}, if_pc, pcEsperado);
    endtask

    initial begin
        mem_pronto = 0; mem_valido = 0; mem_dados = 0; desvio = 0; desvio_alvo = 0; id_pronto = 0;
        w_mem_pronto = 1; w_mem_valido = 0; w_mem_dados = 0; w_desvio = 0; w_desvio_alvo = 0; w_id_pronto = 1;
        wRecord = 1'b1;
        setPhase(100, 100, 0, 1, 1);
        doReset(0);

        // Sequential fetch from reset, 1-cycle memory, no stall
        check("a_endereco_c0", mem_endereco, 32'h0);
        step(1'b0, 32'h0);
        check("a_endereco_c1", mem_endereco, 32'h4);
        step(1'b0, 32'h0);
        check("a_if_valido_c2", 32'(if_valido), 32'd1);
        check("a_if_pc_c2", if_pc, 32'h0);
        check("a_if_pc_mais4_c2", if_pc_mais4, 32'h4);
        step(1'b0, 32'h0);
        check("a_if_pc_c3", if_pc, 32'h4);
        repeat (16) step(1'b0, 32'h0);
        wRecord = 1'b0;

        // PC wrap from 0xFFFFFFF8
        check("w_contagem", 32'((wAcc.size() >= 3) && (wIfPc.size() >= 3)), 32'd1);
        if (wAcc.size() >= 3 && wIfPc.size() >= 3) begin
            check("w_acc0", wAcc[0], 32'hFFFF_FFF8);
            check("w_acc1", wAcc[1], 32'hFFFF_FFFC);
            check("w_acc2", wAcc[2], 32'h0000_0000);
            check("w_ifpc0", wIfPc[0], 32'hFFFF_FFF8);
            check("w_ifpc1", wIfPc[1], 32'hFFFF_FFFC);
            check("w_ifpc2", wIfPc[2], 32'h0000_0000);
            check("w_ifinstr1", wIfInstr[1], dataOf(32'hFFFF_FFFC));
            check("w_ifpc4_1", wIfPc4[1], 32'h0000_0000);
        end

        // Decode stall: credit limit caps fetches at the queue depth
        doReset(0);
        setPhase(100, 0, 0, 1, 1);
        repeat (10) step(1'b0, 32'h0);
        check("b_aceitos", 32'(envAccepts), 32'd4);
        check("b_ocupacao", 32'(ocupacao), 32'd4);
        check("b_mem_req", 32'(mem_req), 32'd0);
        check("b_if_pc", if_pc, 32'h0);
        setPhase(100, 100, 0, 1, 1);
        repeat (20) step(1'b0, 32'h0);

        // Redirect with two fetches in flight, 3-cycle memory
        doReset(0);
        setPhase(100, 100, 0, 3, 3);
        repeat (2) step(1'b0, 32'h0);
        step(1'b1, 32'h100);
        check("c_endereco_alvo", mem_endereco, 32'h100);
        check("c_ocupacao", 32'(ocupacao), 32'd2);
        waitValid("c_primeiro", 32'h100);
        repeat (3) step(1'b0, 32'h0);
        step(1'b1, 32'h103);
        check("c_alvo_alinhado", mem_endereco, 32'h100);
        waitValid("c_segundo", 32'h100);
        repeat (10) step(1'b0, 32'h0);

        // Redirect coinciding with a response and a pop
        doReset(0);
        setPhase(100, 100, 0, 1, 1);
        repeat (4) step(1'b0, 32'h0);
        step(1'b1, 32'h200);
        check("d_if_valido", 32'(if_valido), 32'd0);
        check("d_ocupacao", 32'(ocupacao), 32'd0);
        check("d_endereco", mem_endereco, 32'h200);
        repeat (10) step(1'b0, 32'h0);

        // Randomized traffic: latency, backpressure, redirects
        doReset(0);
        setPhase(70, 65, 6, 1, 4);
        repeat (500) step(1'b0, 32'h0);

        // Asynchronous reset between edges with traffic pending
        doReset(3);
        check("f_endereco_reinicio", mem_endereco, 32'h0);
        check("f_if_valido_reinicio", 32'(if_valido), 32'd0);
        setPhase(80, 80, 3, 1, 3);
        repeat (60) step(1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
